id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, with integrated load-use hazard detection.
- Captures decoded operands, register indices and control from ID on each clock.
- Presents them to EX, the forwarding unit and the ALU.
- Inserts a one-cycle bubble and raises a stall toward PC/IF-ID when a load in EX feeds the instruction in ID.

Parameters:
DATA_W, 32, width of register data, immediate and PC fields
CNT_W, 16, width of the saturating load-use bubble counter

Ports:
clk_i  input  1  core clock, all state updates on rising edge
rst_i  input  1  synchronous reset, active-low
Stall_i  input  1  global freeze (memory stall); hold all state
Flush_i  input  1  branch taken in ID; instruction in ID is squashed
IDValid_i  input  1  ID holds a real instruction
IDRs1_i  input  5  source register 1 index
IDRs2_i  input  5  source register 2 index
IDRd_i  input  5  destination register index
IDRs1Data_i  input  DATA_W  register file read data 1
IDRs2Data_i  input  DATA_W  register file read data 2
IDImm_i  input  DATA_W  sign-extended immediate
IDPC_i  input  DATA_W  instruction PC
IDCtrl_i  input  8  {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch, ALUOp[1:0]}, MSB first
IDFunct_i  input  10  {funct7, funct3}
EXValid_o  output  1  EX holds a real instruction
EXRs1_o / EXRs2_o / EXRd_o  output  5 each  registered indices
EXRs1Data_o / EXRs2Data_o / EXImm_o / EXPC_o  output  DATA_W each  registered data
EXCtrl_o  output  8  registered control, same packing as IDCtrl_i
EXFunct_o  output  10  registered funct
LoadUseStall_o  output  1  freeze PC and IF/ID, this cycle
BubbleCnt_o  output  CNT_W  count of load-use bubbles inserted

Behaviour:
- Reset: rst_i==0 at a rising edge clears every registered output to 0, including EXValid_o and BubbleCnt_o. LoadUseStall_o is therefore 0 the following cycle. Reset overrides all other inputs.
- LoadUseStall_o is combinational from registered EX state and ID inputs. It is 1 iff all of the following hold:
  - EXValid_o
  - EXCtrl_o MemRead bit
  - EXRd_o != 0
  - IDValid_i
  - (EXRd_o == IDRs1_i or EXRd_o == IDRs2_i)
- The rs2 match is checked regardless of instruction format; this is conservative by design.
- Edge priority, highest first: reset > Stall_i > Flush_i > LoadUseStall_o > normal load.
- Stall_i=1: all registers hold, including BubbleCnt_o. Flush_i and the load-use condition are ignored that cycle. Upstream keeps Flush_i asserted while frozen.
- Bubble (Flush_i=1, or LoadUseStall_o=1, or IDValid_i=0):
  - EXValid_o=0, EXCtrl_o=0, EXFunct_o=0.
  - EXRs1_o=EXRs2_o=EXRd_o=0, so no forwarding match is possible.
  - Data fields are cleared to 0.
- Normal load: every EX output takes the corresponding ID input, with 1-cycle latency.
- BubbleCnt_o increments by 1 on each edge where a load-use bubble is inserted (LoadUseStall_o=1, Stall_i=0, Flush_i=0). It saturates at 2^CNT_W-1. Flush bubbles are not counted.
- A load-use stall lasts exactly one cycle: after the bubble, EXCtrl_o MemRead=0, so the stall deasserts and the held ID instruction loads on the next edge.
- Back-to-back load-use pairs (lw; lw dependent; add dependent) each produce exactly one bubble.
- Reset mid-stall: the stall drops the cycle after reset; the held ID instruction is not captured on the reset edge.

Test Plan:
- Reset: drive random ID inputs with rst_i=0 for 2 edges -> all outputs 0, LoadUseStall_o=0. Release -> next edge EX outputs equal the ID inputs presented.
- Pass-through: IDValid_i=1, IDRd_i=7, IDRs1Data_i=0x1234, IDCtrl_i=0x81 -> one edge later EXRd_o=7, EXRs1Data_o=0x1234, EXCtrl_o=0x81, EXValid_o=1.
- Load-use: lw x5 loaded into EX (Ctrl=0xE0), then ID=add x6,x5,x1 -> LoadUseStall_o=1 for one cycle, next EX is a bubble (EXValid_o=0, EXRd_o=0), following edge EXRs1_o=5, BubbleCnt_o=1.
- No false hazard: lw x0 in EX with ID rs1=0, and separately lw x5 with IDValid_i=0 -> LoadUseStall_o=0, no bubble counted.
- Stall vs flush: Stall_i=1 and Flush_i=1 together for 3 cycles -> EX outputs and BubbleCnt_o unchanged. Stall_i drops with Flush_i=1 -> bubble on next edge.
- Saturation: CNT_W=4, generate 20 load-use pairs -> BubbleCnt_o reaches 15 and stays at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection and bubble counter
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              Stall_i,
  input  logic              Flush_i,
  input  logic              IDValid_i,
  input  logic [4:0]        IDRs1_i,
  input  logic [4:0]        IDRs2_i,
  input  logic [4:0]        IDRd_i,
  input  logic [DATA_W-1:0] IDRs1Data_i,
  input  logic [DATA_W-1:0] IDRs2Data_i,
  input  logic [DATA_W-1:0] IDImm_i,
  input  logic [DATA_W-1:0] IDPC_i,
  input  logic [7:0]        IDCtrl_i,
  input  logic [9:0]        IDFunct_i,
  output logic              EXValid_o,
  output logic [4:0]        EXRs1_o,
  output logic [4:0]        EXRs2_o,
  output logic [4:0]        EXRd_o,
  output logic [DATA_W-1:0] EXRs1Data_o,
  output logic [DATA_W-1:0] EXRs2Data_o,
  output logic [DATA_W-1:0] EXImm_o,
  output logic [DATA_W-1:0] EXPC_o,
  output logic [7:0]        EXCtrl_o,
  output logic [9:0]        EXFunct_o,
  output logic              LoadUseStall_o,
  output logic [CNT_W-1:0]  BubbleCnt_o
);

  // Control packing, MSB first: RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch, ALUOp[1:0]
  localparam int CtrlMemRead = 5;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              valid_q,     valid_d;
  logic [4:0]        rs1_q,       rs1_d;
  logic [4:0]        rs2_q,       rs2_d;
  logic [4:0]        rd_q,        rd_d;
  logic [DATA_W-1:0] rs1_data_q,  rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q,  rs2_data_d;
  logic [DATA_W-1:0] imm_q,       imm_d;
  logic [DATA_W-1:0] pc_q,        pc_d;
  logic [7:0]        ctrl_q,      ctrl_d;
  logic [9:0]        funct_q,     funct_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic load_use;
  logic rd_matches;
  logic insert_bubble;
  logic count_bubble;

  // Load in EX whose destination is read by the valid instruction in ID.
  // rs2 is compared even for formats without rs2: a spurious stall costs
  // one cycle, a missed one corrupts data.
  always_comb begin
    rd_matches = (rd_q == IDRs1_i) || (rd_q == IDRs2_i);
    load_use   = valid_q && ctrl_q[CtrlMemRead] && (rd_q != 5'd0) &&
                 IDValid_i && rd_matches;
  end

  // Any reason the ID instruction must not enter EX this edge; a flush
  // takes precedence over a load-use stall for counting purposes.
  always_comb begin
    insert_bubble = Flush_i || load_use || !IDValid_i;
    count_bubble  = !Stall_i && !Flush_i && load_use;
  end

  // Next pipeline state: hold on freeze, zero on bubble, otherwise capture ID.
  always_comb begin
    valid_d    = valid_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    ctrl_d     = ctrl_q;
    funct_d    = funct_q;
    if (!Stall_i) begin
      if (insert_bubble) begin
        valid_d    = 1'b0;
        rs1_d      = 5'd0;
        rs2_d      = 5'd0;
        rd_d       = 5'd0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
        pc_d       = '0;
        ctrl_d     = 8'd0;
        funct_d    = 10'd0;
      end else begin
        valid_d    = 1'b1;
        rs1_d      = IDRs1_i;
        rs2_d      = IDRs2_i;
        rd_d       = IDRd_i;
        rs1_data_d = IDRs1Data_i;
        rs2_data_d = IDRs2Data_i;
        imm_d      = IDImm_i;
        pc_d       = IDPC_i;
        ctrl_d     = IDCtrl_i;
        funct_d    = IDFunct_i;
      end
    end
  end

  // Saturating count of load-use bubbles only.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (count_bubble && (bubble_cnt_q != CntMax)) begin
      bubble_cnt_d = bubble_cnt_q + CntOne;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q      <= 1'b0;
      rs1_q        <= 5'd0;
      rs2_q        <= 5'd0;
      rd_q         <= 5'd0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      ctrl_q       <= 8'd0;
      funct_q      <= 10'd0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      pc_q         <= pc_d;
      ctrl_q       <= ctrl_d;
      funct_q      <= funct_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign EXValid_o      = valid_q;
  assign EXRs1_o        = rs1_q;
  assign EXRs2_o        = rs2_q;
  assign EXRd_o         = rd_q;
  assign EXRs1Data_o    = rs1_data_q;
  assign EXRs2Data_o    = rs2_data_q;
  assign EXImm_o        = imm_q;
  assign EXPC_o         = pc_q;
  assign EXCtrl_o       = ctrl_q;
  assign EXFunct_o      = funct_q;
  assign LoadUseStall_o = load_use;
  assign BubbleCnt_o    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized self-checking bench for id_ex_stage against a reference model
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              Stall_i;
  logic              Flush_i;
  logic              IDValid_i;
  logic [4:0]        IDRs1_i;
  logic [4:0]        IDRs2_i;
  logic [4:0]        IDRd_i;
  logic [DATA_W-1:0] IDRs1Data_i;
  logic [DATA_W-1:0] IDRs2Data_i;
  logic [DATA_W-1:0] IDImm_i;
  logic [DATA_W-1:0] IDPC_i;
  logic [7:0]        IDCtrl_i;
  logic [9:0]        IDFunct_i;
  logic              EXValid_o;
  logic [4:0]        EXRs1_o;
  logic [4:0]        EXRs2_o;
  logic [4:0]        EXRd_o;
  logic [DATA_W-1:0] EXRs1Data_o;
  logic [DATA_W-1:0] EXRs2Data_o;
  logic [DATA_W-1:0] EXImm_o;
  logic [DATA_W-1:0] EXPC_o;
  logic [7:0]        EXCtrl_o;
  logic [9:0]        EXFunct_o;
  logic              LoadUseStall_o;
  logic [CNT_W-1:0]  BubbleCnt_o;

  int checks = 0;
  int errors = 0;

  // Expected contents of the EX stage, as an instruction record.
  typedef struct {
    logic              valid;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [7:0]        ctrl;
    logic [9:0]        funct;
    int                bubbles;
  } ex_t;

  ex_t m;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .Stall_i(Stall_i), .Flush_i(Flush_i),
    .IDValid_i(IDValid_i), .IDRs1_i(IDRs1_i), .IDRs2_i(IDRs2_i), .IDRd_i(IDRd_i),
    .IDRs1Data_i(IDRs1Data_i), .IDRs2Data_i(IDRs2Data_i), .IDImm_i(IDImm_i),
    .IDPC_i(IDPC_i), .IDCtrl_i(IDCtrl_i), .IDFunct_i(IDFunct_i),
    .EXValid_o(EXValid_o), .EXRs1_o(EXRs1_o), .EXRs2_o(EXRs2_o), .EXRd_o(EXRd_o),
    .EXRs1Data_o(EXRs1Data_o), .EXRs2Data_o(EXRs2Data_o), .EXImm_o(EXImm_o),
    .EXPC_o(EXPC_o), .EXCtrl_o(EXCtrl_o), .EXFunct_o(EXFunct_o),
    .LoadUseStall_o(LoadUseStall_o), .BubbleCnt_o(BubbleCnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void clear_model();
    m.valid = 1'b0; m.rs1 = 0; m.rs2 = 0; m.rd = 0;
    m.d1 = 0; m.d2 = 0; m.imm = 0; m.pc = 0; m.ctrl = 0; m.funct = 0;
  endfunction

  // A load (MemRead) in EX writing a nonzero register that the next valid instruction reads.
  function automatic logic hazard();
    return m.valid && m.ctrl[5] && (m.rd != 0) && IDValid_i &&
           ((m.rd == IDRs1_i) || (m.rd == IDRs2_i));
  endfunction

  function automatic void advance_model(input logic lu);
    if (!rst_i) begin
      clear_model();
      m.bubbles = 0;
    end else if (!Stall_i) begin
      if (!Flush_i && lu && m.bubbles < (2**CNT_W - 1)) m.bubbles++;
      if (Flush_i || lu || !IDValid_i) begin
        clear_model();
      end else begin
        m.valid = 1'b1; m.rs1 = IDRs1_i; m.rs2 = IDRs2_i; m.rd = IDRd_i;
        m.d1 = IDRs1Data_i; m.d2 = IDRs2Data_i; m.imm = IDImm_i; m.pc = IDPC_i;
        m.ctrl = IDCtrl_i; m.funct = IDFunct_i;
      end
    end
  endfunction

  task automatic check_outputs();
    check("ex_valid", 64'(EXValid_o), 64'(m.valid));
    check("ex_rs1", 64'(EXRs1_o), 64'(m.rs1));
    check("ex_rs2", 64'(EXRs2_o), 64'(m.rs2));
    check("ex_rd", 64'(EXRd_o), 64'(m.rd));
    check("ex_rs1_data", 64'(EXRs1Data_o), 64'(m.d1));
    check("ex_rs2_data", 64'(EXRs2Data_o), 64'(m.d2));
    check("ex_imm", 64'(EXImm_o), 64'(m.imm));
    check("ex_pc", 64'(EXPC_o), 64'(m.pc));
    check("ex_ctrl", 64'(EXCtrl_o), 64'(m.ctrl));
    check("ex_funct", 64'(EXFunct_o), 64'(m.funct));
    check("bubble_cnt", 64'(BubbleCnt_o), 64'(m.bubbles));
  endtask

  // One clock: check the combinational stall, take the edge, check registered state.
  task automatic tick();
    logic lu;
    #1;
    lu = hazard();
    check("load_use_stall", 64'(LoadUseStall_o), 64'(lu));
    @(posedge clk_i);
    advance_model(lu);
    #1;
    check_outputs();
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [7:0] ctrl);
    IDValid_i = v; IDRs1_i = r1; IDRs2_i = r2; IDRd_i = rd; IDCtrl_i = ctrl;
    IDRs1Data_i = $urandom; IDRs2Data_i = $urandom; IDImm_i = $urandom;
    IDPC_i = $urandom; IDFunct_i = 10'($urandom);
  endtask

  task automatic randomize_id();
    set_id(1'b1, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
           5'($urandom_range(0, 5)), 8'($urandom));
    IDValid_i = ($urandom_range(0, 9) != 0);
  endtask

  initial begin
    m.bubbles = 0;
    clear_model();
    Stall_i = 1'b0; Flush_i = 1'b0; rst_i = 1'b0;

    // Reset with garbage on the ID side
    for (int i = 0; i < 2; i++) begin
      randomize_id();
      IDCtrl_i = 8'hE0; IDValid_i = 1'b1;
      tick();
    end
    check("reset_stall_low", 64'(LoadUseStall_o), 64'd0);
    rst_i = 1'b1;
    randomize_id(); IDValid_i = 1'b1;
    tick();

    // Pass-through
    set_id(1'b1, 5'd1, 5'd2, 5'd7, 8'h81);
    IDRs1Data_i = 32'h1234;
    tick();
    check("pass_rd", 64'(EXRd_o), 64'd7);
    check("pass_data", 64'(EXRs1Data_o), 64'h1234);
    check("pass_ctrl", 64'(EXCtrl_o), 64'h81);

    // Load-use: lw x5 then add x6,x5,x1
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 8'hE0); tick();
    set_id(1'b1, 5'd5, 5'd1, 5'd6, 8'h80);
    #1 check("lu_stall_high", 64'(LoadUseStall_o), 64'd1);
    tick();
    check("lu_bubble_valid", 64'(EXValid_o), 64'd0);
    check("lu_bubble_rd", 64'(EXRd_o), 64'd0);
    tick();
    check("lu_after_rs1", 64'(EXRs1_o), 64'd5);
    check("lu_after_cnt", 64'(BubbleCnt_o), 64'd1);

    // No false hazards: lw x0, and lw x5 followed by invalid ID
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 8'hE0); tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 8'h80); tick();
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 8'hE0); tick();
    set_id(1'b0, 5'd5, 5'd5, 5'd3, 8'h80); tick();
    check("no_false_cnt", 64'(BubbleCnt_o), 64'd1);

    // Stall together with flush holds everything, then flush bubbles
    set_id(1'b1, 5'd1, 5'd2, 5'd9, 8'hE0); tick();
    Stall_i = 1'b1; Flush_i = 1'b1;
    set_id(1'b1, 5'd9, 5'd3, 5'd4, 8'h80);
    for (int i = 0; i < 3; i++) tick();
    check("stall_hold_rd", 64'(EXRd_o), 64'd9);
    Stall_i = 1'b0;
    tick();
    check("flush_bubble_valid", 64'(EXValid_o), 64'd0);
    check("flush_not_counted", 64'(BubbleCnt_o), 64'd1);
    Flush_i = 1'b0;

    // Reset in the middle of a load-use stall
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 8'hE0); tick();
    set_id(1'b1, 5'd5, 5'd0, 5'd6, 8'h80);
    rst_i = 1'b0; tick();
    rst_i = 1'b1; tick();

    // Saturation of the bubble counter
    for (int i = 0; i < 20; i++) begin
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 8'hE0); tick();
      set_id(1'b1, 5'd3, 5'd5, 5'd6, 8'h80); tick(); tick();
    end
    check("bubble_saturated", 64'(BubbleCnt_o), 64'd15);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      randomize_id();
      if ($urandom_range(0, 2) == 0) IDCtrl_i[5] = 1'b1;
      Stall_i = ($urandom_range(0, 9) == 0);
      Flush_i = ($urandom_range(0, 9) == 0);
      rst_i   = ($urandom_range(0, 39) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
